fm_fsk_seq: RTL and testbench
=============================

Name: fm_fsk_seq

Overview:
Byte-serial FSK sequencer that drives the shift-frequency input of the fm_tx modulator. It accepts bytes over a valid/ready handshake and frames each one UART-style: start bit, 8 data bits LSB first, stop bit. It presents the mark or space shift (Hz) for exactly p_bit_clks cycles per bit. It runs in the PLL clock domain alongside fm_tx, replacing the free-running shift counter in the top level.

Parameters:
p_hz_sz, 32, width of all frequency ports; matches the fm_tx p_hz_sz.
p_bit_clks, 192000, clock cycles per symbol; must be >= 2. The default gives 1 kbaud at 192 MHz.

Ports:
i_clk  input  1  clock; same clock as fm_tx.
i_nrst  input  1  reset, asynchronous assert, active-low.
i_en  input  1  enable; low aborts any frame and holds the block idle.
i_mark_hz  input  p_hz_sz  shift for idle, stop bit and data bit 1; sampled every cycle.
i_space_hz  input  p_hz_sz  shift for start bit and data bit 0; sampled every cycle.
i_valid  input  1  byte offered.
i_data  input  8  byte to send; captured on handshake.
o_ready  output  1  block can accept a byte this cycle.
o_busy  output  1  frame in progress.
o_shift_hz  output  p_hz_sz  to fm_tx i_shift_hz.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_nrst is asynchronous and active-low.
- Reset values: state IDLE, bit counter 0, cycle counter 0, shift register 0, o_ready 0, o_busy 0, o_shift_hz 0. In the first cycle after reset release, o_shift_hz takes i_mark_hz.
- States: IDLE, START, DATA, STOP.
- Cycle counter: clog2(p_bit_clks) bits. Counts 0..p_bit_clks-1 within each symbol. It resets to 0 at every symbol boundary, never free-runs.
- o_shift_hz is registered. It carries the value for the current state:
  - IDLE: mark.
  - START: space.
  - DATA: shreg[0] ? mark : space.
  - STOP: mark.
- o_ready (combinational from state and counter) = i_en && (state==IDLE || (state==STOP && cnt==p_bit_clks-1)).
- Handshake: a transfer occurs when i_valid && o_ready. On transfer, i_data goes into shreg, state becomes START, cnt=0.
- Latency: the space shift appears on o_shift_hz the cycle after the transfer.
- START: lasts p_bit_clks cycles, then goes to DATA with bit counter 0.
- DATA: each bit lasts p_bit_clks cycles. At the end of a bit, shreg shifts right by 1 and the bit counter increments. After bit 7 ends, go to STOP.
- STOP: lasts p_bit_clks cycles. At its last cycle:
  - with a transfer: go straight to START (back-to-back, no idle gap, continuous symbol timing);
  - without a transfer: go to IDLE.
- o_busy = (state != IDLE), registered.
- i_data and i_valid are ignored whenever o_ready is low. The upstream side must hold i_valid and i_data until the transfer.
- i_en low in any state: next cycle state=IDLE, counters cleared, o_shift_hz=mark. The partial frame is dropped and no byte is accepted while i_en is low.
- Mark/space changes mid-frame take effect on the next cycle's output.
- Frame length is exactly 10*p_bit_clks cycles, from the first START cycle to the last STOP cycle.

Test Plan:
- Reset with p_bit_clks=4, mark=1000, space=2000, i_en=1: outputs 0 during reset, o_shift_hz=1000 one cycle after release; o_ready=1, o_busy=0.
- Send 0xA5: o_shift_hz per 4-cycle symbol = 2000, then 1000,2000,1000,2000,2000,1000,2000,1000, then 1000. Frame is 40 cycles. o_busy is high for exactly 40 cycles and o_ready is low except on the last STOP cycle.
- Hold i_valid with 0x00 then 0xFF back-to-back: the second START follows the last STOP cycle with no gap. The 80-cycle output is checked symbol by symbol.
- Drop i_en at cycle 13 of a 0x3C frame: at cycle 14, o_shift_hz=1000, o_busy=0, o_ready=0. Re-raising i_en makes o_ready=1 in the same cycle.
- Change i_space_hz to 3000 mid-frame during a 0 data bit: the output becomes 3000 the next cycle, and symbol timing is unchanged.
- Assert i_nrst low mid-DATA, asynchronously: outputs clear immediately without a clock edge. After release, a fresh 0x81 frame transmits correctly.

Source files
------------

// File: rtl/fm_fsk_seq.sv
// Byte-serial FSK sequencer for fm_tx: frames each byte as start, 8 data bits LSB first, stop,
// and holds the mark or space shift on o_shift_hz for p_bit_clks cycles per bit.
module fm_fsk_seq #(
    parameter int p_hz_sz    = 32,
    parameter int p_bit_clks = 192000
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_en,
    input  logic [p_hz_sz-1:0] i_mark_hz,
    input  logic [p_hz_sz-1:0] i_space_hz,
    input  logic               i_valid,
    input  logic [7:0]         i_data,
    output logic               o_ready,
    output logic               o_busy,
    output logic [p_hz_sz-1:0] o_shift_hz
);

    localparam int cnt_w = (p_bit_clks > 1) ? $clog2(p_bit_clks) : 1;
    localparam logic [cnt_w-1:0] cnt_max = cnt_w'(p_bit_clks - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         bit_q, bit_d;
    logic [cnt_w-1:0]   cnt_q, cnt_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [p_hz_sz-1:0] shift_q, shift_d;
    logic               busy_q, busy_d;
    logic               run_q;
    logic               cnt_last;
    logic               xfer;

    // run_q keeps o_ready low until the first clock after reset release.
    assign cnt_last = (cnt_q == cnt_max);
    assign o_ready  = run_q && i_en && (state_q == IDLE || (state_q == STOP && cnt_last));
    assign xfer     = i_valid && o_ready;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_last ? '0 : cnt_q + 1'b1;
        if (!i_en) begin
            state_d = IDLE;
            bit_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (xfer) begin
                        shreg_d = i_data;
                        state_d = START;
                    end
                end
                START: begin
                    if (cnt_last) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        shreg_d = {1'b0, shreg_q[7:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == 3'd7) state_d = STOP;
                    end
                end
                STOP: begin
                    if (cnt_last) begin
                        if (xfer) begin
                            shreg_d = i_data;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Output shift follows the state being entered, so it lands one cycle after the decision.
        unique case (state_d)
            START:   shift_d = i_space_hz;
            DATA:    shift_d = shreg_d[0] ? i_mark_hz : i_space_hz;
            default: shift_d = i_mark_hz;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= IDLE;
            bit_q   <= '0;
            cnt_q   <= '0;
            shreg_q <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            run_q   <= 1'b1;
        end
    end

    assign o_shift_hz = shift_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_fm_fsk_seq.sv
// Bench for fm_fsk_seq: directed frames plus random traffic against a per-cycle queue model
// where each queued entry is the line level (1 = mark, 0 = space) still owed for one cycle.
module tb_fm_fsk_seq;

    localparam int HZ = 32;
    localparam int BC = 4;

    logic          clk = 1'b0;
    logic          nrst;
    logic          en;
    logic          valid;
    logic [7:0]    data;
    logic [HZ-1:0] mark;
    logic [HZ-1:0] space;
    logic          ready;
    logic          busy;
    logic [HZ-1:0] shift_hz;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit sym_q[$];
    bit run_m = 1'b0;
    bit last_xfer = 1'b0;

    fm_fsk_seq #(.p_hz_sz(HZ), .p_bit_clks(BC)) dut (
        .i_clk      (clk),
        .i_nrst     (nrst),
        .i_en       (en),
        .i_mark_hz  (mark),
        .i_space_hz (space),
        .i_valid    (valid),
        .i_data     (data),
        .o_ready    (ready),
        .o_busy     (busy),
        .o_shift_hz (shift_hz)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic pushFrame(input logic [7:0] d);
        for (int k = 0; k < BC; k++) sym_q.push_back(1'b0);
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < BC; k++) sym_q.push_back(d[b]);
        for (int k = 0; k < BC; k++) sym_q.push_back(1'b1);
    endtask

    // One clock of stimulus; ready is judged before the edge, shift/busy just after it.
    task automatic applyStimulus(input logic e, input logic v, input logic [7:0] d);
        logic          exp_rdy;
        logic          xf;
        logic [HZ-1:0] m_s;
        logic [HZ-1:0] s_s;
        logic [HZ-1:0] exp_shift;
        @(negedge clk);
        en = e; valid = v; data = d;
        #1;
        exp_rdy = run_m && e && (sym_q.size() <= 1);
        checkOutput("ready", 32'(ready), 32'(exp_rdy));
        xf  = v && exp_rdy;
        m_s = mark;
        s_s = space;
        @(posedge clk);
        cyc++;
        run_m = 1'b1;
        if (!e) begin
            sym_q.delete();
        end else begin
            if (sym_q.size() > 0) void'(sym_q.pop_front());
            if (xf) pushFrame(d);
        end
        #1;
        exp_shift = (sym_q.size() == 0) ? m_s : (sym_q[0] ? m_s : s_s);
        checkOutput("shift", shift_hz, exp_shift);
        checkOutput("busy", 32'(busy), 32'(sym_q.size() != 0));
        last_xfer = xf;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_shift"}, shift_hz, 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_ready"}, 32'(ready), 32'd0);
    endtask

    initial begin
        int busy_cnt;
        int t_first;
        int t_second;
        int idx;
        logic [7:0] b2b [2];
        logic [7:0] pend;
        logic       pv;
        logic       re;

        nrst = 1'b0; en = 1'b1; valid = 1'b0; data = 8'h00;
        mark = 32'd1000; space = 32'd2000;
        #1;
        checkResetOutputs("rst0");
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("rst1");
        #2 nrst = 1'b1;

        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("post_rst_shift", shift_hz, 32'd1000);
        applyStimulus(1'b1, 1'b0, 8'h00);

        // Single 0xA5 frame, busy must cover exactly 10 symbols.
        busy_cnt = 0;
        applyStimulus(1'b1, 1'b1, 8'hA5);
        if (busy) busy_cnt++;
        for (int i = 0; i < 10 * BC; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h00);
            if (busy) busy_cnt++;
        end
        checkOutput("a5_busy_len", busy_cnt, 10 * BC);

        // 0x00 then 0xFF with valid held: second START must follow the first STOP directly.
        b2b[0] = 8'h00; b2b[1] = 8'hFF;
        idx = 0; t_first = 0; t_second = 0;
        for (int i = 0; i < 20 * BC + 4; i++) begin
            applyStimulus(1'b1, idx < 2, (idx < 2) ? b2b[idx] : 8'h00);
            if (last_xfer) begin
                if (idx == 0) t_first = cyc; else t_second = cyc;
                idx++;
            end
        end
        checkOutput("b2b_gap", t_second - t_first, 10 * BC);

        // Enable drop inside a 0x3C frame, then re-enable.
        applyStimulus(1'b1, 1'b1, 8'h3C);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h77);
        checkOutput("endrop_shift", shift_hz, 32'd1000);
        applyStimulus(1'b1, 1'b0, 8'h00);

        // Space change while a 0 data bit is on the line.
        applyStimulus(1'b1, 1'b1, 8'hF0);
        for (int i = 0; i < BC + 1; i++) applyStimulus(1'b1, 1'b0, 8'h00);
        space = 32'd3000;
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("space_change", shift_hz, 32'd3000);
        for (int i = 0; i < 10 * BC; i++) applyStimulus(1'b1, 1'b0, 8'h00);
        space = 32'd2000;

        // Asynchronous reset in the middle of the data bits, then a fresh 0x81 frame.
        applyStimulus(1'b1, 1'b1, 8'h55);
        for (int i = 0; i < 3 * BC; i++) applyStimulus(1'b1, 1'b0, 8'h00);
        #2 nrst = 1'b0; valid = 1'b1;
        #1;
        checkResetOutputs("async_rst");
        sym_q.delete();
        run_m = 1'b0;
        @(posedge clk);
        #1;
        checkResetOutputs("async_hold");
        valid = 1'b0;
        #2 nrst = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h81);
        for (int i = 0; i < 10 * BC + 2; i++) applyStimulus(1'b1, 1'b0, 8'h00);

        // Random traffic: upstream holds valid/data until accepted, enable glitches occasionally.
        pv = 1'b0; pend = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if (!pv && ($urandom_range(0, 2) == 0)) begin
                pv   = 1'b1;
                pend = 8'($urandom);
            end
            if ($urandom_range(0, 50) == 0) mark = 32'($urandom_range(500, 1500));
            if ($urandom_range(0, 50) == 0) space = 32'($urandom_range(1600, 4000));
            re = ($urandom_range(0, 60) != 0);
            applyStimulus(re, pv, pend);
            if (last_xfer) pv = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
